// File: rtl/dmem_line_server.sv
// rtl/dmem_line_server.sv - backing line memory serving cache refills and write-backs
// One refill in flight at a time; write-backs land every cycle regardless of state.
module dmem_line_server #(
  parameter int          LINES     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          LINE_W    = 128,
  parameter int          LATENCY   = 3,
  parameter logic [15:0] CNT_RESET = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_line,
  output logic              rd_valid,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_line,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wb_count,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [LINE_W-1:0] dbg_line
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] mem [LINES];
  logic [ADDR_W-1:0] load_addr;
  logic [LINE_W-1:0] load_line;

  // IDLE only loads directly when LATENCY==1; a same-edge write-back wins.
  assign load_addr = (state == IDLE) ? rd_addr : req_addr;
  assign load_line = (wb_we && (wb_addr == load_addr)) ? wb_line : mem[load_addr];
  assign dbg_line  = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (!rst && wb_we) begin
      mem[wb_addr] <= wb_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      req_addr <= '0;
      rd_valid <= 1'b0;
      rd_line  <= '0;
      busy     <= 1'b0;
      rd_count <= CNT_RESET;
      wb_count <= CNT_RESET;
    end else begin
      rd_valid <= 1'b0;
      if (wb_we && (wb_count != 16'hFFFF)) begin
        wb_count <= wb_count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (rd_req) begin
            req_addr <= rd_addr;
            busy     <= 1'b1;
            if (rd_count != 16'hFFFF) begin
              rd_count <= rd_count + 16'd1;
            end
            if (LATENCY == 1) begin
              state    <= RESP;
              rd_valid <= 1'b1;
              rd_line  <= load_line;
            end else begin
              state <= WAIT;
              cnt   <= CNT_START;
            end
          end
        end
        WAIT: begin
          if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= RESP;
            rd_valid <= 1'b1;
            rd_line  <= load_line;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_server.sv
// tb/tb_dmem_line_server.sv - self-checking bench for dmem_line_server
// Transaction-level model predicts outputs every cycle; directed literals pin key cases.
module tb_dmem_line_server;

  localparam int LAT = 3;
  localparam logic [127:0] V9 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] VB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [127:0] VC = 128'hCCCC_1111_CCCC_2222_CCCC_3333_CCCC_4444;
  localparam logic [127:0] VE = 128'hEEEE_0000_0000_0000_0000_0000_0000_EEEE;
  localparam logic [127:0] VF = 128'hFFFF_0F0F_F0F0_0F0F_F0F0_0F0F_F0F0_FFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req, rd_req1;
  logic [3:0]   rd_addr, wb_addr, dbg_addr;
  logic         wb_we;
  logic [127:0] wb_line;
  logic [127:0] rd_line, dbg_line, rd_line1, dbg_line1;
  logic         rd_valid, busy, rd_valid1, busy1;
  logic [15:0]  rd_count, wb_count, rd_count1, wb_count1;

  always #5 clk = ~clk;

  dmem_line_server #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_line(rd_line),
    .rd_valid(rd_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_line(wb_line),
    .busy(busy), .rd_count(rd_count), .wb_count(wb_count), .dbg_addr(dbg_addr),
    .dbg_line(dbg_line)
  );

  dmem_line_server #(.LATENCY(1), .CNT_RESET(16'hFFFE)) dut1 (
    .clk(clk), .rst(rst), .rd_req(rd_req1), .rd_addr(rd_addr), .rd_line(rd_line1),
    .rd_valid(rd_valid1), .wb_we(wb_we), .wb_addr(wb_addr), .wb_line(wb_line),
    .busy(busy1), .rd_count(rd_count1), .wb_count(wb_count1), .dbg_addr(dbg_addr),
    .dbg_line(dbg_line1)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] pre(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(i);
    return {w, w, w, w};
  endfunction

  // Model: an accepted read in cycle c returns in cycle c+LAT, sampling memory at the
  // edge before it with write-first; the return cycle itself refuses new requests.
  logic [127:0] mm [16];
  bit           mw [16];
  int           mc = 0;
  int           m_due;
  bit           m_pend, m_valid;
  logic [3:0]   m_addr;
  logic [127:0] m_line;
  logic [15:0]  m_rdc, m_wbc;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 1'b0; m_valid = 1'b0; m_line = '0; m_rdc = 16'd0; m_wbc = 16'd0;
    end else begin
      m_valid = 1'b0;
      if (m_pend && mc == m_due) begin
        m_pend = 1'b0;
      end else if (!m_pend && rd_req) begin
        m_pend = 1'b1; m_addr = rd_addr; m_due = mc + LAT;
        if (m_rdc != 16'hFFFF) m_rdc = m_rdc + 16'd1;
      end
      if (m_pend && mc + 1 == m_due) begin
        m_valid = 1'b1;
        m_line  = (wb_we && wb_addr == m_addr) ? wb_line : mm[m_addr];
      end
      if (wb_we) begin
        mm[wb_addr] = wb_line; mw[wb_addr] = 1'b1;
        if (m_wbc != 16'hFFFF) m_wbc = m_wbc + 16'd1;
      end
    end
    mc++;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_rd_valid", 128'(rd_valid), 128'(m_valid));
      chk("m_busy", 128'(busy), 128'(m_pend));
      chk("m_rd_line", rd_line, m_line);
      chk("m_rd_count", 128'(rd_count), 128'(m_rdc));
      chk("m_wb_count", 128'(wb_count), 128'(m_wbc));
      if (mw[dbg_addr]) chk("m_dbg_line", dbg_line, mm[dbg_addr]);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Holds the request until rd_valid is seen; returns the line and cycle offset.
  task automatic do_read(input bit sel, input logic [3:0] a,
                         output logic [127:0] line, output int k);
    k = -1;
    line = '0;
    rd_addr = a;
    if (sel) rd_req1 = 1'b1; else rd_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((sel ? rd_valid1 : rd_valid) === 1'b1) begin
        k = i;
        line = sel ? rd_line1 : rd_line;
        break;
      end
    end
    #1;
    rd_req = 1'b0;
    rd_req1 = 1'b0;
  endtask

  // Read line 2 with a write-back landing on the load edge (cycle 2).
  task automatic collide(input logic [3:0] wa, input logic [127:0] wd,
                         output logic [127:0] line, output logic v);
    step();
    rd_addr = 4'd2;
    rd_req = 1'b1;
    step();
    step();
    wb_we = 1'b1; wb_addr = wa; wb_line = wd;
    @(negedge clk);
    v = rd_valid;
    line = rd_line;
    #1;
    wb_we = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] line;
    int           k;
    logic         v;

    rst = 1'b1; rd_req = 1'b0; rd_req1 = 1'b0; rd_addr = '0;
    wb_we = 1'b0; wb_addr = '0; wb_line = '0; dbg_addr = '0;
    step();
    step();
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rd_line", rd_line, 128'(0));
    chk("rst_rd_count", 128'(rd_count), 128'(0));
    chk("rst_wb_count", 128'(wb_count), 128'(0));
    mon_en = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wb_we = 1'b1; wb_addr = 4'(i); wb_line = pre(i);
      step();
    end
    wb_we = 1'b0;
    step();

    // Latency/handshake on line 5
    rd_addr = 4'd5;
    rd_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", c), 128'(rd_valid), 128'(c == 3));
      chk($sformatf("t1_busy_c%0d", c), 128'(busy), 128'(c <= 3));
      if (c == 3) begin
        chk("t1_line", rd_line, 128'hD0000005_D0000005_D0000005_D0000005);
        #1 rd_req = 1'b0;
      end
    end
    #1;
    chk("t1_rd_count", 128'(rd_count), 128'(1));

    // Write-back then read line 9
    wb_we = 1'b1; wb_addr = 4'd9; wb_line = V9; dbg_addr = 4'd9;
    step();
    wb_we = 1'b0;
    chk("t2_dbg9", dbg_line, V9);
    chk("t2_wb_count", 128'(wb_count), 128'(17));
    do_read(1'b0, 4'd9, line, k);
    chk("t2_line", line, V9);
    chk("t2_lat", 128'(k), 128'(3));

    // Collision bypass, then a non-colliding write on the load edge
    collide(4'd2, VB, line, v);
    chk("t3_valid", 128'(v), 128'(1));
    chk("t3_line_bypass", line, VB);
    dbg_addr = 4'd2;
    step();
    chk("t3_dbg2", dbg_line, VB);
    collide(4'd3, VC, line, v);
    chk("t3b_valid", 128'(v), 128'(1));
    chk("t3b_line_old", line, VB);
    dbg_addr = 4'd3;
    step();
    chk("t3b_dbg3", dbg_line, VC);

    // Refill, eviction next cycle, re-request the cycle after
    do_read(1'b0, 4'd4, line, k);
    chk("t4_line_a", line, 128'hD0000004_D0000004_D0000004_D0000004);
    step();
    wb_we = 1'b1; wb_addr = 4'd7; wb_line = VE;
    step();
    wb_we = 1'b0;
    do_read(1'b0, 4'd4, line, k);
    chk("t4_lat_b", 128'(k), 128'(3));
    chk("t4_line_b", line, 128'hD0000004_D0000004_D0000004_D0000004);
    dbg_addr = 4'd7;
    step();
    chk("t4_dbg7", dbg_line, VE);

    // Reset mid-WAIT, with a write-back in the reset cycle
    rd_addr = 4'd1;
    rd_req = 1'b1;
    step();
    rst = 1'b1; wb_we = 1'b1; wb_addr = 4'd10; wb_line = VF;
    step();
    rst = 1'b0; wb_we = 1'b0; rd_req = 1'b0; dbg_addr = 4'd10;
    chk("t5_rd_line", rd_line, 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_rd_count", 128'(rd_count), 128'(0));
    chk("t5_wb_count", 128'(wb_count), 128'(0));
    chk("t5_dbg10", dbg_line, 128'hD000000A_D000000A_D000000A_D000000A);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_no_valid", 128'(rd_valid), 128'(0));
      #1;
    end
    do_read(1'b0, 4'd1, line, k);
    chk("t5_lat", 128'(k), 128'(3));
    chk("t5_line", line, 128'hD0000001_D0000001_D0000001_D0000001);

    // LATENCY=1 instance with counters preset near saturation
    chk("t6_rd_count_start", 128'(rd_count1), 128'(16'hFFFE));
    step();
    do_read(1'b1, 4'd0, line, k);
    chk("t6_lat0", 128'(k), 128'(1));
    chk("t6_line0", line, 128'hD0000000_D0000000_D0000000_D0000000);
    chk("t6_busy_resp", 128'(busy1), 128'(1));
    chk("t6_cnt0", 128'(rd_count1), 128'(16'hFFFF));
    step();
    chk("t6_busy_idle", 128'(busy1), 128'(0));
    do_read(1'b1, 4'd2, line, k);
    chk("t6_lat2", 128'(k), 128'(1));
    chk("t6_line2", line, VB);
    chk("t6_cnt2", 128'(rd_count1), 128'(16'hFFFF));
    step();
    do_read(1'b1, 4'd3, line, k);
    chk("t6_lat3", 128'(k), 128'(1));
    chk("t6_line3", line, VC);
    chk("t6_cnt3", 128'(rd_count1), 128'(16'hFFFF));
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
